// File: rtl/mac_seq_pkg.sv
// Shared constants and state encoding for the MAC job sequencer.
package mac_seq_pkg;

    localparam logic [6:0] F7_MAC12 = 7'd0;
    localparam logic [6:0] F7_CLR   = 7'd1;
    localparam logic [6:0] F7_MAC1  = 7'd4;

    localparam int LIMIT12_DEFAULT = 324;
    localparam int LIMIT1_DEFAULT  = 108;

    typedef enum logic [2:0] {
        IDLE,
        CLR_CMD,
        CLR_RSP,
        FETCH,
        MAC_CMD,
        MAC_RSP,
        DONE
    } seq_state_e;

endpackage

// File: rtl/mac_job_sequencer.sv
// Feeds one dot-product job (clear + one MAC per input word) to the filter MAC CFU.
// Optional MAC_SEQ_BIAS_EN adds a per-job bias to the returned accumulator.
//
// state   | meaning
// IDLE    | waiting for a job descriptor
// CLR_CMD | issuing accumulator clear
// CLR_RSP | waiting for clear response
// FETCH   | pulling next input word
// MAC_CMD | issuing MAC for current word
// MAC_RSP | waiting for MAC response, capturing accumulator
// DONE    | presenting result until accepted
module mac_job_sequencer
    import mac_seq_pkg::*;
#(
    parameter int LEN_W   = 9,
    parameter int LIMIT12 = LIMIT12_DEFAULT,
    parameter int LIMIT1  = LIMIT1_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_filt_base,
    input  logic [LEN_W-1:0] job_len,
    input  logic             job_depth1,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [31:0]      job_bias,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             cfu_cmd_valid,
    input  logic             cfu_cmd_ready,
    output logic [9:0]       cfu_cmd_function_id,
    output logic [31:0]      cfu_cmd_inputs_0,
    output logic [31:0]      cfu_cmd_inputs_1,
    input  logic             cfu_rsp_valid,
    output logic             cfu_rsp_ready,
    input  logic [31:0]      cfu_rsp_outputs_0,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_err,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             depth1_q, depth1_d;
    logic             err_q, err_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      result;
    logic [LEN_W:0]   range_sum, range_limit;
    logic [LEN_W-1:0] filt_idx, cnt_inc;

`ifdef MAC_SEQ_BIAS_EN
    logic [31:0] bias_q, bias_d;
    assign result = acc_q + bias_q;
`else
    assign result = acc_q;
`endif

    assign filt_idx    = base_q + cnt_q;
    assign cnt_inc     = cnt_q + 1'b1;
    assign range_sum   = {1'b0, job_filt_base} + {1'b0, job_len};
    assign range_limit = job_depth1 ? (LEN_W+1)'(LIMIT1) : (LEN_W+1)'(LIMIT12);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        depth1_d = depth1_q;
        err_d    = err_q;
        word_d   = word_q;
        acc_d    = acc_q;
`ifdef MAC_SEQ_BIAS_EN
        bias_d   = bias_q;
`endif
        job_ready           = 1'b0;
        in_ready            = 1'b0;
        cfu_cmd_valid       = 1'b0;
        cfu_cmd_function_id = '0;
        cfu_cmd_inputs_0    = '0;
        cfu_cmd_inputs_1    = '0;
        cfu_rsp_ready       = 1'b0;
        res_valid           = 1'b0;
        res_data            = '0;
        res_err             = 1'b0;
        busy                = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    base_d   = job_filt_base;
                    len_d    = job_len;
                    depth1_d = job_depth1;
                    cnt_d    = '0;
                    acc_d    = '0;
`ifdef MAC_SEQ_BIAS_EN
                    bias_d   = job_bias;
`endif
                    // Out-of-range jobs never touch the CFU.
                    if (range_sum > range_limit) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = CLR_CMD;
                    end
                end
            end
            CLR_CMD: begin
                cfu_cmd_valid       = 1'b1;
                cfu_cmd_function_id = {F7_CLR, 3'b000};
                if (cfu_cmd_ready) state_d = CLR_RSP;
            end
            CLR_RSP: begin
                cfu_rsp_ready = 1'b1;
                if (cfu_rsp_valid) begin
                    if (len_q == '0) begin
                        acc_d   = cfu_rsp_outputs_0;
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    state_d = MAC_CMD;
                end
            end
            MAC_CMD: begin
                cfu_cmd_valid       = 1'b1;
                cfu_cmd_function_id = {(depth1_q ? F7_MAC1 : F7_MAC12), 3'b000};
                cfu_cmd_inputs_0    = word_q;
                cfu_cmd_inputs_1    = {{(32-LEN_W){1'b0}}, filt_idx};
                if (cfu_cmd_ready) state_d = MAC_RSP;
            end
            MAC_RSP: begin
                cfu_rsp_ready = 1'b1;
                if (cfu_rsp_valid) begin
                    acc_d   = cfu_rsp_outputs_0;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_err   = err_q;
                res_data  = err_q ? 32'd0 : result;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // While reset is held the outputs already look like IDLE.
        if (!reset) begin
            job_ready           = 1'b1;
            in_ready            = 1'b0;
            cfu_cmd_valid       = 1'b0;
            cfu_cmd_function_id = '0;
            cfu_cmd_inputs_0    = '0;
            cfu_cmd_inputs_1    = '0;
            cfu_rsp_ready       = 1'b0;
            res_valid           = 1'b0;
            res_data            = '0;
            res_err             = 1'b0;
            busy                = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            depth1_q <= 1'b0;
            err_q    <= 1'b0;
            word_q   <= '0;
            acc_q    <= '0;
`ifdef MAC_SEQ_BIAS_EN
            bias_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            depth1_q <= depth1_d;
            err_q    <= err_d;
            word_q   <= word_d;
            acc_q    <= acc_d;
`ifdef MAC_SEQ_BIAS_EN
            bias_q   <= bias_d;
`endif
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural filter-MAC CFU responder.
module tb_mac_job_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        job_valid, job_ready, job_depth1;
    logic [8:0]  job_filt_base, job_len;
`ifdef MAC_SEQ_BIAS_EN
    logic [31:0] job_bias;
`endif
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        cfu_cmd_valid, cfu_cmd_ready;
    logic [9:0]  cfu_cmd_function_id;
    logic [31:0] cfu_cmd_inputs_0, cfu_cmd_inputs_1;
    logic        cfu_rsp_valid, cfu_rsp_ready;
    logic [31:0] cfu_rsp_outputs_0;
    logic        res_valid, res_ready, res_err, busy;
    logic [31:0] res_data;

    always #5 clk = ~clk;

    mac_job_sequencer dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_filt_base(job_filt_base), .job_len(job_len), .job_depth1(job_depth1),
`ifdef MAC_SEQ_BIAS_EN
        .job_bias(job_bias),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfu_cmd_valid(cfu_cmd_valid), .cfu_cmd_ready(cfu_cmd_ready),
        .cfu_cmd_function_id(cfu_cmd_function_id),
        .cfu_cmd_inputs_0(cfu_cmd_inputs_0), .cfu_cmd_inputs_1(cfu_cmd_inputs_1),
        .cfu_rsp_valid(cfu_rsp_valid), .cfu_rsp_ready(cfu_rsp_ready),
        .cfu_rsp_outputs_0(cfu_rsp_outputs_0),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // CFU filter memories and accumulator
    logic [31:0] filt_vals   [0:323];
    logic [31:0] filt_vals_1 [0:107];
    int          cfu_acc = 0;

    function automatic int mac12(input int a, input logic [31:0] x, input logic [31:0] f);
        int r = a;
        for (int b = 0; b < 4; b++)
            r += (int'($signed(x[8*b +: 8])) + 128) * int'($signed(f[8*b +: 8]));
        return r;
    endfunction

    function automatic int mac1(input int a, input logic [31:0] x, input logic [31:0] f);
        return a + (int'($signed(x)) + 128) * int'($signed(f));
    endfunction

    // Backpressure knobs and bookkeeping
    int bp_cmd = 0, bp_in = 0, bp_res = 0;
    int cmd_wait = 0, in_gap = 0, res_wait = 0;
    bit chk_stable = 0;
    logic [31:0] words_q[$];

    bit cmd_fire, rsp_fire, in_fire, cfu_rst;
    logic [9:0]  cap_fid;
    logic [31:0] cap_in0, cap_in1;
    int cyc = 0, job_cyc = 0, res_cyc = 0, job_cnt = 0, res_cnt = 0;
    int cmd_count = 0;
    bit cmd_valid_seen = 0, in_ready_seen = 0;
    logic [9:0]  log_fid [0:7];
    logic [31:0] log_in1 [0:7];
    logic [31:0] got_data;
    logic        got_err;
    bit          prev_cmd_stall = 0, prev_res_stall = 0;
    logic [9:0]  prev_fid;
    logic [31:0] prev_in0, prev_in1, prev_res;

    // Observe handshakes just before the DUT's state update
    always @(posedge clk) begin
        cyc++;
        cfu_rst  = cfu_rst | !reset;
        cmd_fire = cfu_cmd_valid && cfu_cmd_ready;
        rsp_fire = cfu_rsp_valid && cfu_rsp_ready;
        in_fire  = in_valid && in_ready;
        if (cfu_cmd_valid) cmd_valid_seen = 1;
        if (in_ready) in_ready_seen = 1;
        if (cmd_fire) begin
            cap_fid = cfu_cmd_function_id;
            cap_in0 = cfu_cmd_inputs_0;
            cap_in1 = cfu_cmd_inputs_1;
            if (cmd_count < 8) begin
                log_fid[cmd_count] = cfu_cmd_function_id;
                log_in1[cmd_count] = cfu_cmd_inputs_1;
            end
            cmd_count++;
        end
        if (job_valid && job_ready && reset) begin
            job_cnt++;
            job_cyc = cyc;
        end
        if (res_valid && res_ready) begin
            got_data = res_data;
            got_err  = res_err;
            res_cnt++;
            res_cyc  = cyc;
        end
        if (chk_stable) begin
            if (busy) check_eq("job_ready_busy", {31'd0, job_ready}, 32'd0);
            if (prev_cmd_stall && cfu_cmd_valid) begin
                check_eq("stall_fid", {22'd0, cfu_cmd_function_id}, {22'd0, prev_fid});
                check_eq("stall_in0", cfu_cmd_inputs_0, prev_in0);
                check_eq("stall_in1", cfu_cmd_inputs_1, prev_in1);
            end
            if (prev_cmd_stall) check_eq("stall_cmd_valid", {31'd0, cfu_cmd_valid}, 32'd1);
            if (prev_res_stall) begin
                check_eq("stall_res_valid", {31'd0, res_valid}, 32'd1);
                check_eq("stall_res_data", res_data, prev_res);
            end
        end
        prev_cmd_stall = cfu_cmd_valid && !cfu_cmd_ready;
        prev_res_stall = res_valid && !res_ready;
        prev_fid = cfu_cmd_function_id;
        prev_in0 = cfu_cmd_inputs_0;
        prev_in1 = cfu_cmd_inputs_1;
        prev_res = res_data;
    end

    // CFU responder, input feeder and result sink
    always @(negedge clk) begin
        if (cfu_rst) begin
            cfu_rsp_valid = 1'b0;
            cfu_acc = 0;
            cfu_rst = 0;
        end
        if (rsp_fire) cfu_rsp_valid = 1'b0;
        if (cmd_fire) begin
            case (cap_fid[9:3])
                7'd1: cfu_acc = 0;
                7'd0: if (cap_in1 < 324) cfu_acc = mac12(cfu_acc, cap_in0, filt_vals[cap_in1]);
                7'd4: if (cap_in1 < 108) cfu_acc = mac1(cfu_acc, cap_in0, filt_vals_1[cap_in1]);
                default: ;
            endcase
            cfu_rsp_outputs_0 = cfu_acc;
            cfu_rsp_valid = 1'b1;
            cmd_wait = 0;
        end
        cmd_fire = 0;
        rsp_fire = 0;
        if (cfu_cmd_valid) begin
            if (cmd_wait < bp_cmd) begin cfu_cmd_ready = 1'b0; cmd_wait++; end
            else cfu_cmd_ready = 1'b1;
        end else begin
            cmd_wait = 0;
            cfu_cmd_ready = (bp_cmd == 0);
        end

        if (in_fire) begin
            if (words_q.size() > 0) void'(words_q.pop_front());
            in_gap = bp_in;
        end
        in_fire = 0;
        if (words_q.size() > 0 && in_gap == 0) begin
            in_valid = 1'b1;
            in_data  = words_q[0];
        end else begin
            in_valid = 1'b0;
            if (in_gap > 0) in_gap--;
        end

        if (res_valid) begin
            if (res_wait < bp_res) begin res_ready = 1'b0; res_wait++; end
            else res_ready = 1'b1;
        end else begin
            res_wait = 0;
            res_ready = (bp_res == 0);
        end
    end

    task automatic run_job(input logic [8:0] base, input logic [8:0] len, input logic d1);
        int start_job = job_cnt;
        int start_res = res_cnt;
        int n = 0;
        cmd_count = 0;
        cmd_valid_seen = 0;
        in_ready_seen = 0;
        job_filt_base = base;
        job_len = len;
        job_depth1 = d1;
        job_valid = 1'b1;
        while (job_cnt == start_job && n < 50) begin @(negedge clk); n++; end
        job_valid = 1'b0;
        if (job_cnt == start_job) check_eq("job_accept_timeout", 32'd0, 32'd1);
        n = 0;
        while (res_cnt == start_res && n < 500) begin @(negedge clk); n++; end
        if (res_cnt == start_res) check_eq("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_job_ready"}, {31'd0, job_ready}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_valids"}, {28'd0, cfu_cmd_valid, res_valid, in_ready, cfu_rsp_ready}, 32'd0);
        check_eq({tag, "_fid"}, {22'd0, cfu_cmd_function_id}, 32'd0);
        check_eq({tag, "_inputs"}, cfu_cmd_inputs_0 | cfu_cmd_inputs_1, 32'd0);
        check_eq({tag, "_res"}, {res_data[30:0], res_err} | {31'd0, res_data[31]}, 32'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b0;
        job_valid = 1'b0;
        job_filt_base = '0;
        job_len = '0;
        job_depth1 = 1'b0;
`ifdef MAC_SEQ_BIAS_EN
        job_bias = 32'd0;
`endif
        in_valid = 1'b0;
        in_data = '0;
        cfu_cmd_ready = 1'b1;
        cfu_rsp_valid = 1'b0;
        cfu_rsp_outputs_0 = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 324; i++) filt_vals[i] = 32'd0;
        for (int i = 0; i < 108; i++) filt_vals_1[i] = 32'd0;
        filt_vals[0] = 32'h0101_0101;
        filt_vals[1] = 32'h0202_0202;
        filt_vals_1[107] = 32'd3;

        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // depth-12, two words: 4*1*1 + 4*2*2 = 20
        words_q.push_back(32'h8181_8181);
        words_q.push_back(32'h8282_8282);
        run_job(9'd0, 9'd2, 1'b0);
        check_eq("d12_res_data", got_data, 32'd20);
        check_eq("d12_res_err", {31'd0, got_err}, 32'd0);
        check_eq("d12_cmd_count", cmd_count, 32'd3);
        check_eq("d12_fid0", {22'd0, log_fid[0]}, 32'h008);
        check_eq("d12_fid1", {22'd0, log_fid[1]}, 32'h000);
        check_eq("d12_fid2", {22'd0, log_fid[2]}, 32'h000);
        check_eq("d12_idx1", log_in1[1], 32'd0);
        check_eq("d12_idx2", log_in1[2], 32'd1);
        check_eq("d12_latency", res_cyc - job_cyc, 32'd9);

        // depth-1 at the last valid index: (-123+128)*3 = 15
        words_q.push_back(32'hFFFF_FF85);
        run_job(9'd107, 9'd1, 1'b1);
        check_eq("d1_res_data", got_data, 32'd15);
        check_eq("d1_fid", {22'd0, log_fid[1]}, 32'h020);
        check_eq("d1_idx", log_in1[1], 32'd107);
        check_eq("d1_latency", res_cyc - job_cyc, 32'd6);

        // zero length: clear only
        run_job(9'd5, 9'd0, 1'b0);
        check_eq("zero_cmd_count", cmd_count, 32'd1);
        check_eq("zero_in_ready", {31'd0, in_ready_seen}, 32'd0);
        check_eq("zero_res_data", got_data, 32'd0);
        check_eq("zero_res_err", {31'd0, got_err}, 32'd0);
        check_eq("zero_latency", res_cyc - job_cyc, 32'd3);

        // 320 + 5 > 324
        run_job(9'd320, 9'd5, 1'b0);
        check_eq("range_cmd_seen", {31'd0, cmd_valid_seen}, 32'd0);
        check_eq("range_res_err", {31'd0, got_err}, 32'd1);
        check_eq("range_res_data", got_data, 32'd0);
        check_eq("range_latency", res_cyc - job_cyc, 32'd1);

        // 320 + 4 == 324 is still legal
        repeat (4) words_q.push_back(32'h7F7F_7F7F);
        run_job(9'd320, 9'd4, 1'b0);
        check_eq("edge12_res_err", {31'd0, got_err}, 32'd0);
        check_eq("edge12_cmd_count", cmd_count, 32'd5);

        // depth-1: 100 + 9 > 108
        run_job(9'd100, 9'd9, 1'b1);
        check_eq("range1_res_err", {31'd0, got_err}, 32'd1);
        check_eq("range1_cmd_seen", {31'd0, cmd_valid_seen}, 32'd0);

        // backpressure on every handshake
        bp_cmd = 3; bp_in = 2; bp_res = 5; chk_stable = 1;
        words_q.push_back(32'h8181_8181);
        words_q.push_back(32'h8282_8282);
        run_job(9'd0, 9'd2, 1'b0);
        check_eq("bp_res_data", got_data, 32'd20);
        check_eq("bp_res_err", {31'd0, got_err}, 32'd0);
        check_eq("bp_cmd_count", cmd_count, 32'd3);
        @(negedge clk);
        chk_stable = 0; bp_cmd = 0; bp_in = 0; bp_res = 0;
        @(negedge clk);

        // reset while waiting on the first MAC response
        words_q.push_back(32'h8181_8181);
        words_q.push_back(32'h8282_8282);
        cmd_count = 0;
        job_filt_base = 9'd0; job_len = 9'd2; job_depth1 = 1'b0;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (cfu_rsp_ready && cmd_count == 2) found = 1;
            else @(negedge clk);
        end
        check_eq("reach_mac_rsp", {31'd0, found}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b1;
        words_q.delete();
        @(negedge clk);
        check_idle_outputs("post_reset");
        words_q.push_back(32'h8181_8181);
        words_q.push_back(32'h8282_8282);
        run_job(9'd0, 9'd2, 1'b0);
        check_eq("rerun_res_data", got_data, 32'd20);
        check_eq("rerun_cmd_count", cmd_count, 32'd3);
        check_eq("rerun_latency", res_cyc - job_cyc, 32'd9);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Sequences one dot-product job onto the SIMD filter MAC CFU without CPU involvement per word.
- Accepts a job descriptor: filter base index, word count, depth mode (12-deep SIMD or 1-deep scalar).
- Issues an accumulator-clear, then one MAC command per input word pulled from an input stream, and returns the final accumulator on a result handshake.
- Sits between the host/DMA side and the CFU cmd/rsp port; it is the CFU's sole command master while busy.

Parameters:
- LEN_W, 9, width of job length and filter index counters.
- LIMIT12, 324, number of 12-deep filter entries (valid indices 0..323).
- LIMIT1, 108, number of 1-deep filter entries (valid indices 0..107).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- job_valid / job_ready  in / out  1 / 1  job handshake
- job_filt_base  in  LEN_W  first filter index
- job_len  in  LEN_W  number of MAC words (0 allowed)
- job_depth1  in  1  1 = scalar depth-1 MAC (funct7 4); 0 = SIMD depth-12 MAC (funct7 0)
- in_valid / in_ready / in_data  in / out / in  1 / 1 / 32  input word stream
- cfu_cmd_valid / cfu_cmd_ready  out / in  1 / 1  CFU command handshake
- cfu_cmd_function_id  out  10  {funct7, 3'b000}
- cfu_cmd_inputs_0 / cfu_cmd_inputs_1  out / out  32 / 32  input word / filter index, zero-extended
- cfu_rsp_valid / cfu_rsp_ready / cfu_rsp_outputs_0  in / out / in  1 / 1 / 32  CFU response
- res_valid / res_ready / res_data / res_err  out / in / out / out  1 / 1 / 32 / 1  result handshake
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset = 0 at a clk edge) sends the FSM to IDLE regardless of state and clears all counters.
- Output values while in reset or IDLE:
  - job_ready = 1; every other valid/ready output = 0.
  - res_data = 0, res_err = 0, busy = 0.
  - cfu_cmd_function_id and cfu_cmd_inputs_* = 0.
- The CFU must be reset in the same cycle (the integration inverts reset). The sequencer drops any in-flight response.
- IDLE: on job_valid, latch the descriptor and set cnt = 0.
  - Range check uses LEN_W+1 bit arithmetic: limit is LIMIT1 if job_depth1, else LIMIT12.
  - If job_filt_base + job_len > limit: go to DONE with res_err = 1 and res_data = 0. No CFU traffic is issued.
  - Otherwise go to CLR_CMD.
- CLR_CMD: cfu_cmd_valid = 1, funct7 = 1, inputs = 0. On cfu_cmd_ready, go to CLR_RSP.
- CLR_RSP: cfu_rsp_ready = 1. On cfu_rsp_valid:
  - if len == 0, capture the response into acc and go to DONE;
  - else go to FETCH.
- FETCH: in_ready = 1. On in_valid, latch in_data into word and go to MAC_CMD.
- MAC_CMD: cfu_cmd_valid = 1, funct7 = job_depth1 ? 4 : 0, inputs_0 = word, inputs_1 = base + cnt. On cfu_cmd_ready, go to MAC_RSP.
- MAC_RSP: cfu_rsp_ready = 1. On cfu_rsp_valid:
  - acc <= cfu_rsp_outputs_0 and cnt <= cnt + 1;
  - if cnt + 1 == len go to DONE, else go to FETCH.
- DONE: res_valid = 1; res_data and res_err are held stable. On res_ready, go to IDLE.
- Handshake rules:
  - Every valid output stays asserted with stable payload until its ready is seen; it never deasserts early.
  - Exactly one CFU command is outstanding at a time.
  - job_ready = 1 only in IDLE.
- Latency with all readies tied high: 2 cycles for the clear, then 3 cycles per word (FETCH, CMD, RSP), then 1 cycle in DONE.
- A new job is accepted no earlier than the cycle after the DONE handshake.
- Arithmetic: the accumulator is owned by the CFU. The sequencer only captures it; no wrap handling is needed beyond 32-bit.

Optional Feature:
- Macro MAC_SEQ_BIAS_EN.
- Defined:
  - adds input port job_bias (32 bits), latched with the job;
  - on entry to DONE (non-error), res_data = acc + bias, modulo 2^32;
  - on an error job, res_data = 0 and the bias is ignored.
- Undefined: job_bias port is absent and res_data = acc.

Decomposition:
- Package mac_seq_pkg holds:
  - funct7 constants: F7_MAC12 = 0, F7_CLR = 1, F7_MAC1 = 4;
  - LIMIT12 and LIMIT1 defaults;
  - state enum {IDLE, CLR_CMD, CLR_RSP, FETCH, MAC_CMD, MAC_RSP, DONE}.
- No sub-module: this is a single FSM plus counter. The bench pairs it with the existing CFU.

Test Plan:
- Depth-12 job: preload filt_vals[0] = 0x01010101 and [1] = 0x02020202; job base = 0, len = 2; inputs 0x81818181 then 0x82828282 -> CFU sees funct7 1, 0, 0 with inputs_1 = 0, 1; res_data = 20, res_err = 0.
- Depth-1 job: filt_vals_1[107] = 3; job base = 107, len = 1, job_depth1 = 1; input 0xFFFFFF85 -> cmd function_id = 0x020; res_data = 15.
- Zero length: base = 5, len = 0 -> exactly one CFU command (clear); in_ready never high; res_data = 0.
- Range error: depth-12 base = 320, len = 5 -> cfu_cmd_valid never asserts; res_valid within 2 cycles with res_err = 1 and res_data = 0.
- Backpressure on the depth-12 job above:
  - stimulus: cfu_cmd_ready low 3 cycles per command, in_valid gaps of 2 cycles, res_ready low 5 cycles;
  - required: payloads stable while stalled, job_ready = 0 throughout, result 20.
- Reset mid-job: drive reset = 0 during MAC_RSP -> next cycle IDLE, busy = 0, all valids = 0; a new job then runs correctly to completion.
